// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion.
// Latency: 1 cycle from decode to EX; hazard_stall is combinational in the same cycle.
// Backpressure: stall_in holds all EX contents; flush overrides stall and clears EX.
//
// Ports:
//   clk, rst            clock and async active-high reset
//   flush, stall_in     branch kill and downstream hold
//   id_*                decode-slot payload (register file read data and decoded fields)
//   wb_we/addr/data     writeback port, used only for same-cycle bypass
//   hazard_stall        freeze PC and IF/ID this cycle
//   ex_*                registered payload presented to execute
//   bubble_cnt          saturating count of load-use bubbles
//
// Optional feature macro: WB_BYPASS_EN (writeback-to-operand bypass on capture).
module id_ex_stage_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 8,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall_in,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [ADDR_W-1:0] ex_rs1,
    output logic [ADDR_W-1:0] ex_rs2,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [15:0]       bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              reg_write;
    } ex_t;

    ex_t         ex_q, ex_d, id_cap;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [DATA_W-1:0] op1_sel, op2_sel;
    logic        load_use;

`ifdef WB_BYPASS_EN
    // A write landing this cycle is not yet visible on the register file read ports.
    assign op1_sel = (wb_we && (wb_addr == id_rs1)) ? wb_data : id_rdata1;
    assign op2_sel = (wb_we && (wb_addr == id_rs2)) ? wb_data : id_rdata2;
`else
    logic wb_unused;
    assign wb_unused = ^{wb_we, wb_addr, wb_data};
    assign op1_sel   = id_rdata1;
    assign op2_sel   = id_rdata2;
`endif

    // Register 0 is treated like any other register here.
    assign load_use = ex_q.valid & ex_q.mem_read & ex_q.reg_write & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_use_rs2 & (id_rs2 == ex_q.rd)));

    assign hazard_stall = ~rst & ~flush & (stall_in | load_use);

    always_comb begin
        id_cap           = '0;
        id_cap.valid     = id_valid;
        id_cap.pc        = id_pc;
        id_cap.op1       = op1_sel;
        id_cap.op2       = op2_sel;
        id_cap.rs1       = id_rs1;
        id_cap.rs2       = id_rs2;
        id_cap.rd        = id_rd;
        id_cap.imm       = id_imm;
        // An empty slot must never carry side-effecting control into EX.
        id_cap.ctrl      = id_valid ? id_ctrl : '0;
        id_cap.mem_read  = id_valid & id_mem_read;
        id_cap.reg_write = id_valid & id_reg_write;
    end

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall_in) begin
            ex_d = ex_q;
        end else if (load_use) begin
            // The bubble in EX cannot match next cycle, so one bubble resolves the hazard.
            ex_d = '0;
            if (bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end else begin
            ex_d = id_cap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_op1       = ex_q.op1;
    assign ex_op2       = ex_q.op2;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_imm       = ex_q.imm;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for the decode-to-execute pipeline register.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1-2 units later.
// Expected values are hand-derived constants.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall_in;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_rdata1;
    logic [15:0] id_rdata2;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [15:0] id_imm;
    logic [7:0]  id_ctrl;
    logic        id_mem_read;
    logic        id_reg_write;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic        hazard_stall;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [15:0] ex_imm;
    logic [7:0]  ex_ctrl;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage_reg dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall_in     (stall_in),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_mem_read  (id_mem_read),
        .id_reg_write (id_reg_write),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [15:0] pc, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic u1, input logic u2,
                          input logic [15:0] imm, input logic [7:0] ctrl,
                          input logic mr, input logic rw);
        id_valid     = v;
        id_pc        = pc;
        id_rdata1    = d1;
        id_rdata2    = d2;
        id_rs1       = s1;
        id_rs2       = s2;
        id_rd        = d;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_imm       = imm;
        id_ctrl      = ctrl;
        id_mem_read  = mr;
        id_reg_write = rw;
    endtask

    initial begin
        // Reset with every input nonzero.
        rst = 1'b1; flush = 1'b1; stall_in = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 16'h7777;
        set_id(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd1, 5'd1, 5'd1, 1, 1, 16'hFFFF, 8'hFF, 1, 1);
        #1;
        check("rst_hazard", {31'd0, hazard_stall}, 0);
        check("rst_valid", {31'd0, ex_valid}, 0);
        check("rst_bubble", {16'd0, bubble_cnt}, 0);
        tick();
        check("rst_edge_pc", {16'd0, ex_pc}, 0);
        check("rst_edge_ctrl", {24'd0, ex_ctrl}, 0);
        rst = 1'b0; flush = 1'b0; stall_in = 1'b0; wb_we = 1'b0;

        // Normal flow.
        set_id(1, 16'h0010, 16'hF0F0, 16'h1234, 5'd2, 5'd4, 5'd5, 1, 1, 16'h0007, 8'hA5, 0, 1);
        #1;
        check("norm_hazard", {31'd0, hazard_stall}, 0);
        tick();
        check("norm_valid", {31'd0, ex_valid}, 1);
        check("norm_pc", {16'd0, ex_pc}, 32'h0010);
        check("norm_op1", {16'd0, ex_op1}, 32'hF0F0);
        check("norm_op2", {16'd0, ex_op2}, 32'h1234);
        check("norm_rs1", {27'd0, ex_rs1}, 2);
        check("norm_rs2", {27'd0, ex_rs2}, 4);
        check("norm_rd", {27'd0, ex_rd}, 5);
        check("norm_imm", {16'd0, ex_imm}, 32'h0007);
        check("norm_ctrl", {24'd0, ex_ctrl}, 32'hA5);
        check("norm_flags", {30'd0, ex_mem_read, ex_reg_write}, 32'b01);

        // Asynchronous reset pulsed between edges.
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, ex_valid}, 0);
        check("arst_op1", {16'd0, ex_op1}, 0);
        check("arst_ctrl", {24'd0, ex_ctrl}, 0);
        check("arst_hazard", {31'd0, hazard_stall}, 0);
        rst = 1'b0;

        // No hazard: consumer names rd of the load in rs2 but does not read it.
        set_id(1, 16'h0020, 16'h1111, 16'h2222, 5'd3, 5'd4, 5'd1, 1, 1, 16'h0000, 8'h3C, 1, 1);
        tick();
        check("ld_mr", {31'd0, ex_mem_read}, 1);
        set_id(1, 16'h0022, 16'hAAAA, 16'h5555, 5'd7, 5'd1, 5'd1, 1, 0, 16'h0001, 8'h11, 0, 1);
        #1;
        check("nouse_hazard", {31'd0, hazard_stall}, 0);
        tick();
        check("nouse_valid", {31'd0, ex_valid}, 1);
        check("nouse_pc", {16'd0, ex_pc}, 32'h0022);
        check("nouse_bubble", {16'd0, bubble_cnt}, 0);

        // No hazard: EX writes r1 but is not a load.
        set_id(1, 16'h0024, 16'h0101, 16'h0202, 5'd1, 5'd8, 5'd9, 1, 1, 16'h0002, 8'h22, 0, 1);
        #1;
        check("noload_hazard", {31'd0, hazard_stall}, 0);
        tick();
        check("noload_pc", {16'd0, ex_pc}, 32'h0024);
        check("noload_bubble", {16'd0, bubble_cnt}, 0);

        // Load-use: one bubble, then the dependent instruction is captured.
        set_id(1, 16'h0030, 16'h3333, 16'h4444, 5'd3, 5'd4, 5'd1, 1, 1, 16'h0000, 8'h3C, 1, 1);
        tick();
        set_id(1, 16'h0032, 16'hAAAA, 16'h5555, 5'd7, 5'd1, 5'd6, 1, 1, 16'h0003, 8'h11, 0, 1);
        #1;
        check("lu_hazard", {31'd0, hazard_stall}, 1);
        tick();
        check("lu_bubble_valid", {31'd0, ex_valid}, 0);
        check("lu_bubble_pc", {16'd0, ex_pc}, 0);
        check("lu_bubble_ctrl", {24'd0, ex_ctrl}, 0);
        check("lu_bubble_cnt", {16'd0, bubble_cnt}, 1);
        check("lu_after_hazard", {31'd0, hazard_stall}, 0);
        tick();
        check("lu_cap_valid", {31'd0, ex_valid}, 1);
        check("lu_cap_pc", {16'd0, ex_pc}, 32'h0032);
        check("lu_cap_rd", {27'd0, ex_rd}, 6);
        check("lu_cap_op2", {16'd0, ex_op2}, 32'h5555);
        check("lu_cap_cnt", {16'd0, bubble_cnt}, 1);

        // Flush wins over stall.
        flush = 1'b1; stall_in = 1'b1;
        #1;
        check("fl_hazard", {31'd0, hazard_stall}, 0);
        tick();
        check("fl_valid", {31'd0, ex_valid}, 0);
        check("fl_pc", {16'd0, ex_pc}, 0);
        check("fl_op1", {16'd0, ex_op1}, 0);
        check("fl_rd", {27'd0, ex_rd}, 0);
        check("fl_flags", {30'd0, ex_mem_read, ex_reg_write}, 0);
        check("fl_cnt", {16'd0, bubble_cnt}, 1);
        flush = 1'b0; stall_in = 1'b0;

        // Stall holds for three edges while the decode inputs change.
        set_id(1, 16'h0040, 16'hCAFE, 16'hD00D, 5'd10, 5'd11, 5'd12, 1, 1, 16'h0044, 8'h5A, 0, 1);
        tick();
        stall_in = 1'b1;
        set_id(1, 16'h0050, 16'h9999, 16'h8888, 5'd13, 5'd14, 5'd15, 1, 1, 16'h0055, 8'h77, 1, 1);
        #1;
        check("st_hazard", {31'd0, hazard_stall}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_valid", {31'd0, ex_valid}, 1);
            check("st_pc", {16'd0, ex_pc}, 32'h0040);
            check("st_op1", {16'd0, ex_op1}, 32'hCAFE);
            check("st_ctrl", {24'd0, ex_ctrl}, 32'h5A);
        end
        stall_in = 1'b0;

        // Empty decode slot: control forced off, other fields captured.
        set_id(0, 16'h0060, 16'h6060, 16'h0606, 5'd2, 5'd3, 5'd4, 1, 1, 16'h0066, 8'hEE, 1, 1);
        tick();
        check("inv_valid", {31'd0, ex_valid}, 0);
        check("inv_ctrl", {24'd0, ex_ctrl}, 0);
        check("inv_flags", {30'd0, ex_mem_read, ex_reg_write}, 0);
        check("inv_pc", {16'd0, ex_pc}, 32'h0060);
        check("inv_imm", {16'd0, ex_imm}, 32'h0066);

        // Same-cycle writeback collision on rs1.
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 16'hBEEF;
        set_id(1, 16'h0070, 16'h0000, 16'h1234, 5'd3, 5'd4, 5'd5, 1, 1, 16'h0000, 8'h01, 0, 1);
        tick();
`ifdef WB_BYPASS_EN
        check("byp_op1", {16'd0, ex_op1}, 32'hBEEF);
`else
        check("byp_op1", {16'd0, ex_op1}, 32'h0000);
`endif
        check("byp_op2", {16'd0, ex_op2}, 32'h1234);
        wb_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
